// File: rtl/door_pkg.sv
// Shared types and default timing constants for the door motor controller.
package door_pkg;
    typedef enum logic [2:0] {
        STOPPED = 3'd0,
        CLOSED  = 3'd1,
        OPEN    = 3'd2,
        OPENING = 3'd3,
        CLOSING = 3'd4,
        DEAD    = 3'd5,
        FAULT   = 3'd6
    } door_state_t;

    localparam int DEF_DEAD_CYCLES = 2000;
    localparam int DEF_RUN_TIMEOUT = 40000000;
    localparam int DEF_AUTO_CLOSE  = 60000000;

    // Timer width covering the largest of the three durations.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/door_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module door_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign expired = (count == '0);
endmodule

// File: rtl/door_motor_ctrl.sv
// Garage door motor controller: edge-detected commands, dead time on reversal,
// run timeout, auto-close and a latched fault state.
module door_motor_ctrl
    import door_pkg::*;
#(
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
    parameter int RUN_TIMEOUT = DEF_RUN_TIMEOUT,
    parameter int AUTO_CLOSE  = DEF_AUTO_CLOSE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_open,
    input  logic       key_close,
    input  logic       rmt_open,
    input  logic       rmt_close,
    input  logic       sense_up,
    input  logic       sense_down,
    input  logic       obstacle,
    output logic       ml,
    output logic       mr,
    output logic       light_red,
    output logic       light_green,
    output logic       fault,
    output logic [2:0] db_state
);
    localparam int TW = timer_width(DEAD_CYCLES, RUN_TIMEOUT, AUTO_CLOSE);
    // Loaded value n-1 keeps the state for n cycles, since expiry is count==0.
    localparam logic [TW-1:0] LD_DEAD = TW'(DEAD_CYCLES - 1);
    localparam logic [TW-1:0] LD_RUN  = TW'(RUN_TIMEOUT - 1);
    localparam logic [TW-1:0] LD_AUTO = TW'(AUTO_CLOSE - 1);

    door_state_t   state, next;
    door_state_t   pending, next_pending;
    logic [3:0]    req, req_q, rise;
    logic          post_rst;
    logic          open_ev, close_ev, open_cmd, close_cmd, stop_cmd;
    logic          t_load, t_exp;
    logic [TW-1:0] t_val;

    assign req       = {key_open, key_close, rmt_open, rmt_close};
    assign rise      = req & ~req_q;
    assign open_ev   = rise[3] | rise[1];
    assign close_ev  = rise[2] | rise[0];
    assign stop_cmd  = open_ev & close_ev;
    assign open_cmd  = open_ev & ~close_ev;
    assign close_cmd = close_ev & ~open_ev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= STOPPED;
            pending  <= OPENING;
            req_q    <= '0;
            post_rst <= 1'b1;
        end else begin
            state    <= next;
            pending  <= next_pending;
            req_q    <= req;
            post_rst <= 1'b0;
        end
    end

    always_comb begin
        next         = state;
        next_pending = pending;
        if (sense_up && sense_down) begin
            next = FAULT;
        end else begin
            case (state)
                STOPPED: begin
                    if (post_rst && sense_down)    next = CLOSED;
                    else if (post_rst && sense_up) next = OPEN;
                    else if (open_cmd)             next = OPENING;
                    else if (close_cmd)            next = CLOSING;
                end
                CLOSED:  if (open_cmd) next = OPENING;
                OPEN: begin
                    if (close_cmd) next = CLOSING;
                    else if (t_exp && !obstacle && !open_ev && !close_ev) next = CLOSING;
                end
                OPENING: begin
                    if (sense_up)      next = OPEN;
                    else if (stop_cmd) next = STOPPED;
                    else if (close_cmd) begin
                        next         = DEAD;
                        next_pending = CLOSING;
                    end else if (t_exp) next = FAULT;
                end
                CLOSING: begin
                    // Obstacle outranks both stop and the end sensor.
                    if (obstacle || open_cmd) begin
                        next         = DEAD;
                        next_pending = OPENING;
                    end else if (stop_cmd)   next = STOPPED;
                    else if (sense_down)     next = CLOSED;
                    else if (t_exp)          next = FAULT;
                end
                DEAD: begin
                    if (stop_cmd) begin
                        next = STOPPED;
                    end else begin
                        if (open_cmd)       next_pending = OPENING;
                        else if (close_cmd) next_pending = CLOSING;
                        if (t_exp)          next = next_pending;
                    end
                end
                FAULT:   next = FAULT;
                default: next = FAULT;
            endcase
        end
    end

    // Reload on every state change; in OPEN also on any activity.
    always_comb begin
        t_load = (next != state) ||
                 (state == OPEN && next == OPEN && (obstacle || open_ev || close_ev));
        case (next)
            DEAD:             t_val = LD_DEAD;
            OPENING, CLOSING: t_val = LD_RUN;
            OPEN:             t_val = LD_AUTO;
            default:          t_val = '0;
        endcase
    end

    door_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .expired  (t_exp)
    );

    assign mr          = (state == OPENING);
    assign ml          = (state == CLOSING);
    assign light_green = (state == OPEN);
    assign light_red   = (state != OPEN);
    assign fault       = (state == FAULT);
    assign db_state    = state;
endmodule

// File: tb/tb_door_motor_ctrl.sv
// Table-driven bench with a scoreboard of expected state/outputs per clock.
module tb_door_motor_ctrl;
    import door_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, key_open, key_close, rmt_open, rmt_close;
    logic       sense_up, sense_down, obstacle;
    logic       ml, mr, light_red, light_green, fault;
    logic [2:0] db_state;

    always #5 clk = ~clk;

    door_motor_ctrl #(.DEAD_CYCLES(4), .RUN_TIMEOUT(50), .AUTO_CLOSE(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_open(key_open), .key_close(key_close),
        .rmt_open(rmt_open), .rmt_close(rmt_close),
        .sense_up(sense_up), .sense_down(sense_down), .obstacle(obstacle),
        .ml(ml), .mr(mr), .light_red(light_red), .light_green(light_green),
        .fault(fault), .db_state(db_state)
    );

    // Input bit order: {key_open, key_close, rmt_open, rmt_close, sense_up, sense_down, obstacle}
    localparam logic [6:0] NONE = 7'b0000000, KO = 7'b1000000, KC = 7'b0100000,
                           RO = 7'b0010000, RC = 7'b0001000, SU = 7'b0000100,
                           SD = 7'b0000010, OB = 7'b0000001;

    typedef struct packed { logic r; logic [6:0] in; door_state_t exp; } vec_t;
    typedef struct packed { logic [2:0] st; logic ml, mr, red, green, flt; } obs_t;

    obs_t sb[$];
    vec_t tbl[$];
    int   n_cmp = 0, n_fail = 0, stepno = 0;

    function automatic obs_t expect_of(input door_state_t s);
        obs_t o;
        o.st = s; o.mr = (s == OPENING); o.ml = (s == CLOSING);
        o.green = (s == OPEN); o.red = (s != OPEN); o.flt = (s == FAULT);
        return o;
    endfunction

    function automatic vec_t mk(input logic r, input logic [6:0] in, input door_state_t e);
        vec_t v;
        v.r = r; v.in = in; v.exp = e;
        return v;
    endfunction

    task automatic step(input logic r, input logic [6:0] in, input door_state_t e);
        obs_t want, got;
        rst_n = r;
        {key_open, key_close, rmt_open, rmt_close, sense_up, sense_down, obstacle} = in;
        sb.push_back(expect_of(e));
        @(posedge clk); #1;
        got  = {db_state, ml, mr, light_red, light_green, fault};
        want = sb.pop_front();
        n_cmp++;
        if (got !== want)
            begin
                n_fail++;
                $display("FAIL step%0d: got st=%0d ml=%b mr=%b red=%b grn=%b flt=%b, want st=%0d ml=%b mr=%b red=%b grn=%b flt=%b",
                         stepno, got.st, got.ml, got.mr, got.red, got.green, got.flt,
                         want.st, want.ml, want.mr, want.red, want.green, want.flt);
            end
        stepno++;
    endtask

    always @(negedge clk)
        if (ml && mr) begin
            n_fail++;
            $display("FAIL ml_mr_overlap: ml=%b mr=%b, required never both 1", ml, mr);
        end

    initial begin
        rst_n = 1'b0;
        {key_open, key_close, rmt_open, rmt_close, sense_up, sense_down, obstacle} = NONE;

        tbl.push_back(mk(1'b0, NONE,    STOPPED));
        tbl.push_back(mk(1'b0, SD,      STOPPED));
        tbl.push_back(mk(1'b1, SD,      CLOSED));
        tbl.push_back(mk(1'b1, KO | SD, OPENING));
        tbl.push_back(mk(1'b1, KO,      OPENING));
        tbl.push_back(mk(1'b1, NONE,    OPENING));
        tbl.push_back(mk(1'b1, SU,      OPEN));
        tbl.push_back(mk(1'b1, SU | KO, OPEN));
        tbl.push_back(mk(1'b1, SU | KC, CLOSING));
        tbl.push_back(mk(1'b1, NONE,    CLOSING));
        tbl.push_back(mk(1'b1, RO,      DEAD));
        tbl.push_back(mk(1'b1, NONE,    DEAD));
        tbl.push_back(mk(1'b1, NONE,    DEAD));
        tbl.push_back(mk(1'b1, NONE,    DEAD));
        tbl.push_back(mk(1'b1, NONE,    OPENING));
        tbl.push_back(mk(1'b1, RC,      DEAD));
        tbl.push_back(mk(1'b1, RO,      DEAD));
        tbl.push_back(mk(1'b1, NONE,    DEAD));
        tbl.push_back(mk(1'b1, NONE,    DEAD));
        tbl.push_back(mk(1'b1, NONE,    OPENING));
        tbl.push_back(mk(1'b1, KO | KC, STOPPED));
        tbl.push_back(mk(1'b1, NONE,    STOPPED));
        tbl.push_back(mk(1'b1, KC,      CLOSING));
        tbl.push_back(mk(1'b1, OB | SD, DEAD));
        tbl.push_back(mk(1'b1, NONE,    DEAD));
        tbl.push_back(mk(1'b1, NONE,    DEAD));
        tbl.push_back(mk(1'b1, NONE,    DEAD));
        tbl.push_back(mk(1'b1, NONE,    OPENING));
        tbl.push_back(mk(1'b1, SU | SD, FAULT));
        tbl.push_back(mk(1'b1, KO,      FAULT));
        tbl.push_back(mk(1'b1, KC,      FAULT));
        tbl.push_back(mk(1'b0, NONE,    STOPPED));
        tbl.push_back(mk(1'b1, SU | SD, FAULT));
        tbl.push_back(mk(1'b0, NONE,    STOPPED));
        tbl.push_back(mk(1'b1, SU,      OPEN));
        tbl.push_back(mk(1'b0, NONE,    STOPPED));
        tbl.push_back(mk(1'b1, NONE,    STOPPED));
        tbl.push_back(mk(1'b1, KO,      OPENING));
        tbl.push_back(mk(1'b0, KO,      STOPPED));

        foreach (tbl[i]) step(tbl[i].r, tbl[i].in, tbl[i].exp);

        // Auto-close: twenty idle cycles in OPEN.
        step(1'b0, NONE, STOPPED);
        step(1'b1, SU, OPEN);
        for (int i = 0; i < 19; i++) step(1'b1, NONE, OPEN);
        step(1'b1, NONE, CLOSING);

        // Obstacle in OPEN restarts the twenty-cycle window.
        step(1'b0, NONE, STOPPED);
        step(1'b1, SU, OPEN);
        for (int i = 0; i < 10; i++) step(1'b1, NONE, OPEN);
        step(1'b1, OB, OPEN);
        for (int i = 0; i < 19; i++) step(1'b1, NONE, OPEN);
        step(1'b1, NONE, CLOSING);

        // Run timeout without the end sensor, then fault ignores keys until reset.
        step(1'b0, NONE, STOPPED);
        step(1'b1, NONE, STOPPED);
        step(1'b1, KO, OPENING);
        for (int i = 0; i < 49; i++) step(1'b1, NONE, OPENING);
        step(1'b1, NONE, FAULT);
        step(1'b1, KC, FAULT);
        step(1'b1, KO, FAULT);
        step(1'b1, NONE, FAULT);
        step(1'b0, NONE, STOPPED);

        // Stop command during dead time.
        step(1'b1, NONE, STOPPED);
        step(1'b1, KO, OPENING);
        step(1'b1, KC, DEAD);
        step(1'b1, NONE, DEAD);
        step(1'b1, KO | KC, STOPPED);
        step(1'b1, NONE, STOPPED);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/door_motor_ctrl.md
DOOR_MOTOR_CTRL -- requirements
Module: door_motor_ctrl

Interface
REQ-001 The block SHALL have parameter DEAD_CYCLES, 2000, motor-off cycles enforced before any direction reversal (1 ms at 2 MHz).
REQ-002 The block SHALL have parameter RUN_TIMEOUT, 40000000, maximum cycles in OPENING/CLOSING before fault (20 s).
REQ-003 The block SHALL have parameter AUTO_CLOSE, 60000000, idle cycles in OPEN before automatic close (30 s).
REQ-004 The block SHALL have port clk  in  1  clock, 2 MHz, posedge active.
REQ-005 The block SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port key_open / key_close  in  1 each  local wall-key requests (synchronous level).
REQ-007 The block SHALL have port rmt_open / rmt_close  in  1 each  remote-receiver requests (synchronous level).
REQ-008 The block SHALL have port sense_up / sense_down  in  1 each  upper/lower end-position sensors.
REQ-009 The block SHALL have port obstacle  in  1  light barrier interrupted.
REQ-010 The block SHALL have port ml / mr  out  1 each  motor close / open drive.
REQ-011 The block SHALL have port light_red / light_green  out  1 each  traffic lights.
REQ-012 The block SHALL have port fault  out  1  latched fault indicator.
REQ-013 The block SHALL have port db_state  out  3  encoded current state.

Function
REQ-014 States SHALL be STOPPED=0, CLOSED=1, OPEN=2, OPENING=3, CLOSING=4, DEAD=5, FAULT=6; code 7 SHALL go to FAULT.
REQ-015 Requests SHALL be rising-edge detected per input (previous-cycle register); held levels SHALL NOT retrigger.
REQ-016 Open command = edge on key_open or rmt_open; close command = edge on key_close or rmt_close; both in the same cycle SHALL act as a stop command.
REQ-017 Outputs SHALL be Moore-decoded from the state register only: mr=1 only in OPENING, ml=1 only in CLOSING; ml&mr=1 SHALL never occur.
REQ-018 light_green=1 only in OPEN; light_red=1 in all other states; fault=1 only in FAULT.
REQ-019 A command first visible in cycle n SHALL change state and outputs at the clk edge ending cycle n (1-cycle latency).
REQ-020 STOPPED: open->OPENING, close->CLOSING, stop/none->stay.
REQ-021 CLOSED: open->OPENING; close ignored. OPEN: close->CLOSING; open ignored.
REQ-022 OPENING: sense_up->OPEN; close->DEAD with pending=CLOSING; stop->STOPPED.
REQ-023 CLOSING: sense_down->CLOSED; open or obstacle->DEAD with pending=OPENING; stop->STOPPED; obstacle takes priority over stop and over sense_down.
REQ-024 DEAD SHALL hold both motor outputs 0 for exactly DEAD_CYCLES cycles, then enter pending; stop during DEAD->STOPPED; a new opposite command SHALL overwrite pending without restarting the count.
REQ-025 In OPEN, AUTO_CLOSE consecutive cycles without command and without obstacle SHALL enter CLOSING; obstacle=1 SHALL reload the timer.
REQ-026 OPENING/CLOSING lasting RUN_TIMEOUT cycles without the target sensor SHALL enter FAULT.
REQ-027 sense_up and sense_down both 1 in any state SHALL enter FAULT next edge.
REQ-028 FAULT SHALL be exited only by reset; all commands ignored.
REQ-029 Timer SHALL be reloaded on every state entry; counter width = $clog2 of the largest parameter, no wrap.

Reset
REQ-030 rst_n=0 at a clk edge SHALL force STOPPED, timer=0, edge registers=0, pending=OPENING; ml=mr=light_green=fault=0, light_red=1.
REQ-031 Reset mid-motion SHALL stop the motor at that same edge.
REQ-032 First cycle after reset: sense_down->CLOSED, sense_up->OPEN, both->FAULT, none->STOPPED.

Structure
REQ-033 Package door_pkg SHALL hold typedef door_state_t (3-bit enum) and default constants for DEAD_CYCLES, RUN_TIMEOUT, AUTO_CLOSE.
REQ-034 One sub-module door_timer (loadable down-counter with expire flag) SHALL serve all timing, as only one timer is active per state.

Verification (DEAD_CYCLES=4, RUN_TIMEOUT=50, AUTO_CLOSE=20)
REQ-035 Reset with sense_down=1, key_open pulse -> CLOSED then OPENING, mr=1 one cycle after pulse; sense_up -> OPEN, light_green=1.
REQ-036 CLOSING then rmt_open pulse -> ml=0 next edge, ml=mr=0 for exactly 4 cycles, then mr=1.
REQ-037 CLOSING with obstacle=1 and sense_down=1 in the same cycle -> DEAD, then OPENING.
REQ-038 OPEN, no input -> CLOSING after 20 cycles; obstacle pulse at cycle 10 -> CLOSING at cycle 30.
REQ-039 OPENING with sense_up held 0 -> FAULT after 50 cycles, fault=1, key pulses ignored until rst_n=0.
REQ-040 key_open and key_close edges same cycle while OPENING -> STOPPED; ml and mr asserted together never observed (assertion across all tests).
